// File: rtl/gcore_pkg.sv
// gcore_pkg: shared opcode constants, width defaults and fetch FSM encoding
package gcore_pkg;
    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 12;
    typedef logic [1:0] state_t;
    localparam state_t S_ADDR  = 2'd0;
    localparam state_t S_LATCH = 2'd1;
    localparam state_t S_ADV   = 2'd2;
    localparam state_t S_HALT  = 2'd3;
    typedef logic [3:0] opcode_t;
    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_JMP = 4'h5;
    localparam opcode_t OP_JZ  = 4'h6;
    localparam opcode_t OP_OUT = 4'h7;
    localparam opcode_t OP_HLT = 4'hF;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: phase strobes, ROM port, branch inputs and fetched-instruction outputs
interface fetch_ctrl_if #(
    parameter int ADDR_W  = gcore_pkg::ADDR_W_DEF,
    parameter int INSTR_W = gcore_pkg::INSTR_W_DEF
) ();
    logic               ena;
    logic               pc_stb;
    logic               opram_stb;
    logic [INSTR_W-1:0] rom_data;
    logic               jmp_req;
    logic [ADDR_W-1:0]  jmp_addr;
    logic [ADDR_W-1:0]  rom_addr;
    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  operand;
    logic               ir_valid;
    logic               halted;
    logic               seq_err;
    modport master (
        output ena, pc_stb, opram_stb, rom_data, jmp_req, jmp_addr,
        input  rom_addr, opcode, operand, ir_valid, halted, seq_err
    );
    modport slave (
        input  ena, pc_stb, opram_stb, rom_data, jmp_req, jmp_addr,
        output rom_addr, opcode, operand, ir_valid, halted, seq_err
    );
endinterface

// File: rtl/fetch_ctrl_pc_reg.sv
// pc_reg: program counter with enable, load and modulo-2^W increment
module pc_reg #(
    parameter int          W      = 8,
    parameter logic [W-1:0] RST_PC = '0
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    always_ff @(posedge clk_in or negedge rst)
        if (!rst) o_q <= RST_PC;
        else if (i_en) o_q <= i_load ? i_d : o_q + 1'b1;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: strobe-sequenced instruction fetch FSM with IR, halt and sticky sequence-error flag
module fetch_ctrl
    import gcore_pkg::*;
#(
    parameter int               ADDR_W  = ADDR_W_DEF,
    parameter int               INSTR_W = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic        clk_in,
    input  logic        rst,
    fetch_ctrl_if.slave bus
);
    state_t            r_state, w_next;
    logic [3:0]        r_opcode, w_opc;
    logic [ADDR_W-1:0] r_operand, w_rom_addr;
    logic              r_ir_valid, r_halted, r_seq_err;
    logic              w_pc, w_op, w_go, w_latch, w_adv, w_bad, w_hlt;
    assign w_opc   = bus.rom_data[INSTR_W-1 -: 4];
    assign w_hlt   = w_opc == OP_HLT;
    // a simultaneous pair of strobes never qualifies as a legal event
    assign w_pc    = bus.ena & bus.pc_stb & ~bus.opram_stb;
    assign w_op    = bus.ena & bus.opram_stb & ~bus.pc_stb;
    assign w_go    = w_pc & (r_state == S_ADDR);
    assign w_latch = w_op & (r_state == S_LATCH);
    assign w_adv   = w_pc & (r_state == S_ADV);
    assign w_bad   = bus.ena & (r_state != S_HALT) &
                     ((bus.pc_stb & bus.opram_stb) |
                      (bus.opram_stb & (r_state != S_LATCH)) |
                      (bus.pc_stb & (r_state == S_LATCH)));
    always_comb
        w_next = w_go ? S_LATCH : w_latch ? (w_hlt ? S_HALT : S_ADV) : w_adv ? S_ADDR : r_state;
    always_ff @(posedge clk_in or negedge rst)
        if (!rst) begin
            r_state    <= S_ADDR;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_opcode   <= w_opc;
                r_operand  <= bus.rom_data[ADDR_W-1:0];
                r_ir_valid <= 1'b1;
                r_halted   <= w_hlt;
            end
            if (w_bad) r_seq_err <= 1'b1;
        end
    pc_reg #(.W(ADDR_W), .RST_PC(RST_PC)) u_pc (
        .clk_in (clk_in),
        .rst    (rst),
        .i_en   (w_adv),
        .i_load (bus.jmp_req),
        .i_d    (bus.jmp_addr),
        .o_q    (w_rom_addr)
    );
    assign bus.rom_addr = w_rom_addr;
    assign bus.opcode   = r_opcode;
    assign bus.operand  = r_operand;
    assign bus.ir_valid = r_ir_valid;
    assign bus.halted   = r_halted;
    assign bus.seq_err  = r_seq_err;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: table-driven frames plus corner sequences, checked through an expectation queue
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [11:0] rom [256];
    int checks = 0;
    int errors = 0;
    fetch_ctrl_if #(.ADDR_W(8), .INSTR_W(12)) bus ();
    fetch_ctrl #(.ADDR_W(8), .INSTR_W(12), .RST_PC(8'h00)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    assign bus.rom_data = rom[bus.rom_addr];
    typedef struct {
        logic       jmp;
        logic       jl;
        logic [7:0] ja;
        logic [3:0] opc;
        logic [7:0] opr;
        logic [7:0] addr;
    } vec_t;
    typedef struct {
        logic [3:0] opc;
        logic [7:0] opr;
        logic [7:0] addr;
        logic       hlt;
        logic       err;
        logic       iv;
    } exp_t;
    vec_t tv [10];
    exp_t sb [$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic sb_push(input logic [3:0] opc, input logic [7:0] opr, input logic [7:0] addr,
                           input logic hlt, input logic err, input logic iv);
        sb.push_back('{opc, opr, addr, hlt, err, iv});
    endtask
    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".opcode"},   32'(bus.opcode),   32'(e.opc));
            chk({name, ".operand"},  32'(bus.operand),  32'(e.opr));
            chk({name, ".rom_addr"}, 32'(bus.rom_addr), 32'(e.addr));
            chk({name, ".halted"},   32'(bus.halted),   32'(e.hlt));
            chk({name, ".seq_err"},  32'(bus.seq_err),  32'(e.err));
            chk({name, ".ir_valid"}, 32'(bus.ir_valid), 32'(e.iv));
        end
    endtask
    task automatic cyc(input logic p, input logic o, input logic j, input logic [7:0] ja);
        bus.pc_stb    = p;
        bus.opram_stb = o;
        bus.jmp_req   = j;
        bus.jmp_addr  = ja;
        @(negedge clk);
    endtask
    task automatic frame(input logic jmp, input logic jl, input logic [7:0] ja);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, jl, ja);
        cyc(1'b0, 1'b1, jl, ja);
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, jmp, ja);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        rom[8'h00] = 12'h105; rom[8'h01] = 12'h206; rom[8'h02] = 12'h307;
        rom[8'h03] = 12'h4FE; rom[8'hFF] = 12'h1AA; rom[8'h10] = 12'h2BB;
        rom[8'h40] = 12'h3CC; rom[8'h11] = 12'h0DD; rom[8'h12] = 12'h5EE;
        rom[8'h13] = 12'h6A1; rom[8'h14] = 12'h7B2; rom[8'h05] = 12'hF00;
        tv[0] = '{1'b0, 1'b0, 8'h00, 4'h1, 8'h05, 8'h01};
        tv[1] = '{1'b0, 1'b0, 8'h00, 4'h2, 8'h06, 8'h02};
        tv[2] = '{1'b0, 1'b0, 8'h00, 4'h3, 8'h07, 8'h03};
        tv[3] = '{1'b1, 1'b0, 8'hFF, 4'h4, 8'hFE, 8'hFF};
        tv[4] = '{1'b0, 1'b0, 8'h00, 4'h1, 8'hAA, 8'h00};
        tv[5] = '{1'b1, 1'b0, 8'h10, 4'h1, 8'h05, 8'h10};
        tv[6] = '{1'b1, 1'b0, 8'h40, 4'h2, 8'hBB, 8'h40};
        tv[7] = '{1'b1, 1'b0, 8'h10, 4'h3, 8'hCC, 8'h10};
        tv[8] = '{1'b0, 1'b1, 8'h40, 4'h2, 8'hBB, 8'h11};
        tv[9] = '{1'b0, 1'b0, 8'h00, 4'h0, 8'hDD, 8'h12};
        bus.ena = 1'b1;
        bus.pc_stb = 1'b0;
        bus.opram_stb = 1'b0;
        bus.jmp_req = 1'b0;
        bus.jmp_addr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        sb_push(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        sb_check("reset");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sb_push(tv[i].opc, tv[i].opr, tv[i].addr, 1'b0, 1'b0, 1'b1);
            frame(tv[i].jmp, tv[i].jl, tv[i].ja);
            sb_check($sformatf("vec%0d", i));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        sb_push(4'h0, 8'hDD, 8'h12, 1'b0, 1'b1, 1'b1);
        sb_check("opram_in_addr");
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        sb_push(4'h0, 8'hDD, 8'h12, 1'b0, 1'b1, 1'b1);
        sb_check("both_strobes");
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        sb_push(4'h5, 8'hEE, 8'h12, 1'b0, 1'b1, 1'b1);
        sb_check("latch_same_edge");
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        sb_push(4'h5, 8'hEE, 8'h13, 1'b0, 1'b1, 1'b1);
        sb_check("after_err_frame");
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        bus.ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(k[0], ~k[0], 1'b1, 8'hAA);
            sb_push(4'h5, 8'hEE, 8'h13, 1'b0, 1'b1, 1'b1);
            sb_check($sformatf("ena_hold%0d", k));
        end
        bus.ena = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        sb_push(4'h6, 8'hA1, 8'h14, 1'b0, 1'b1, 1'b1);
        sb_check("ena_resume");
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        sb_push(4'h7, 8'hB2, 8'h14, 1'b0, 1'b1, 1'b1);
        sb_check("pre_reset");
        #2 rst = 1'b0;
        #1;
        sb_push(4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        sb_check("async_reset");
        @(negedge clk);
        rst = 1'b1;
        sb_push(4'h1, 8'h05, 8'h01, 1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, 8'h00);
        sb_check("post_reset_frame");
        sb_push(4'h2, 8'h06, 8'h05, 1'b0, 1'b0, 1'b1);
        frame(1'b1, 1'b0, 8'h05);
        sb_check("jump_to_5");
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        sb_push(4'hF, 8'h00, 8'h05, 1'b1, 1'b0, 1'b1);
        sb_check("halt_latch");
        for (int c = 0; c < 3; c++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 8'h40);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        for (int f = 0; f < 4; f++) begin
            sb_push(4'hF, 8'h00, 8'h05, 1'b1, 1'b0, 1'b1);
            frame(1'b1, 1'b0, 8'h40);
            sb_check($sformatf("halt_frame%0d", f));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
